// File: rtl/timer_ctrl.sv
// Programmable down-counting timer fed by the ripple counter's terminal count; one-shot or auto-reload.
// Tick latency: 2 clk from the edge sampling tick_in to the count update; no backpressure (start/stop/ack are pulses).
module timer_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             irq_q, irq_d;
    logic             expired_q, expired_d;
    logic             busy_q, busy_d;
    logic             s1_q, s2_q, s3_q;
    logic             tick_evt;
    logic             do_load;
    logic             set_irq;

    // s1/s2 resynchronise tick_in; s3 delays s2 so each rising edge yields one event.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tick_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick_evt = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        expired_d = 1'b0;
        set_irq   = 1'b0;
        do_load   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    do_load = 1'b1;
                end
            end
            RUN: begin
                // stop beats start, and both beat a coincident tick
                if (stop) begin
                    state_d = PAUSE;
                end else if (start) begin
                    do_load = 1'b1;
                end else if (tick_evt) begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        expired_d = 1'b1;
                        set_irq   = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            count_d  = load_val;
            reload_d = load_val;
            mode_d   = mode;
            if (load_val == '0) begin
                state_d   = DONE;
                expired_d = 1'b1;
                set_irq   = 1'b1;
            end else begin
                state_d = RUN;
            end
        end

        irq_d  = set_irq | (irq_q & ~irq_ack);
        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            irq_q     <= 1'b0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign expired = expired_q;
    assign irq     = irq_q;
    assign state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: operation table with a scoreboard queue plus hand-written timing sequences.
module tb_timer_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         tick_in = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         mode = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         irq_ack = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
    logic         irq;
    logic [1:0]   state;

    timer_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .tick_in  (tick_in),
        .load_val (load_val),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .irq_ack  (irq_ack),
        .count    (count),
        .busy     (busy),
        .expired  (expired),
        .irq      (irq),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_START, OP_STOP, OP_SS, OP_ACK, OP_TICK} op_e;

    typedef struct {
        op_e          op;
        logic [W-1:0] lv;
        logic         md;
        logic [W-1:0] exp_count;
        logic [1:0]   exp_state;
        logic         exp_irq;
        int           exp_pulses;
    } vec_t;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always @(posedge clk) begin
        #1;
        if (expired === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(op_e op, logic [W-1:0] lv, logic md, logic [W-1:0] c,
                                logic [1:0] s, logic i, int p);
        vec_t v;
        v.op = op; v.lv = lv; v.md = md;
        v.exp_count = c; v.exp_state = s; v.exp_irq = i; v.exp_pulses = p;
        return v;
    endfunction

    task automatic run_op(input int idx, input vec_t v);
        vec_t e;
        int   p0;
        @(negedge clk);
        p0 = pulse_cnt;
        load_val = v.lv;
        mode     = v.md;
        case (v.op)
            OP_START: start = 1'b1;
            OP_STOP:  stop = 1'b1;
            OP_SS:    begin start = 1'b1; stop = 1'b1; end
            OP_ACK:   irq_ack = 1'b1;
            OP_TICK:  tick_in = 1'b1;
            default:  ;
        endcase
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; irq_ack = 1'b0; tick_in = 1'b0;
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("v%0d.count", idx), 32'(count), 32'(e.exp_count));
        chk($sformatf("v%0d.state", idx), 32'(state), 32'(e.exp_state));
        chk($sformatf("v%0d.busy", idx), 32'(busy),
            32'((e.exp_state == S_RUN) || (e.exp_state == S_PAUSE)));
        chk($sformatf("v%0d.irq", idx), 32'(irq), 32'(e.exp_irq));
        chk($sformatf("v%0d.expired_pulses", idx), 32'(pulse_cnt - p0), 32'(e.exp_pulses));
    endtask

    initial begin
        int p0;

        // Asynchronous reset state, checked before any clock edge is involved.
        #1 clr = 1'b0;
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.expired", 32'(expired), 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        chk("rst.state", 32'(state), 32'(S_IDLE));
        repeat (3) @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        vecs.push_back(mk(OP_ACK,   16'd0, 1'b0, 16'd0, S_IDLE,  1'b0, 0));
        vecs.push_back(mk(OP_SS,    16'd5, 1'b0, 16'd0, S_IDLE,  1'b0, 0));
        // one-shot, load 3
        vecs.push_back(mk(OP_START, 16'd3, 1'b0, 16'd3, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd3, 1'b0, 16'd2, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd3, 1'b0, 16'd1, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd3, 1'b0, 16'd0, S_DONE,  1'b1, 1));
        vecs.push_back(mk(OP_TICK,  16'd3, 1'b0, 16'd0, S_DONE,  1'b1, 0));
        vecs.push_back(mk(OP_ACK,   16'd3, 1'b0, 16'd0, S_DONE,  1'b0, 0));
        vecs.push_back(mk(OP_STOP,  16'd3, 1'b0, 16'd0, S_IDLE,  1'b0, 0));
        // periodic, load 2, six ticks
        vecs.push_back(mk(OP_START, 16'd2, 1'b1, 16'd2, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd1, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd2, S_RUN,   1'b1, 1));
        vecs.push_back(mk(OP_ACK,   16'd9, 1'b0, 16'd2, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd1, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd2, S_RUN,   1'b1, 1));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd1, S_RUN,   1'b1, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b0, 16'd2, S_RUN,   1'b1, 1));
        vecs.push_back(mk(OP_STOP,  16'd9, 1'b0, 16'd2, S_PAUSE, 1'b1, 0));
        vecs.push_back(mk(OP_STOP,  16'd9, 1'b0, 16'd0, S_IDLE,  1'b1, 0));
        vecs.push_back(mk(OP_ACK,   16'd9, 1'b0, 16'd0, S_IDLE,  1'b0, 0));
        // pause / resume, load 4
        vecs.push_back(mk(OP_START, 16'd4, 1'b0, 16'd4, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd4, 1'b0, 16'd3, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_STOP,  16'd4, 1'b0, 16'd3, S_PAUSE, 1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd4, 1'b0, 16'd3, S_PAUSE, 1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd4, 1'b0, 16'd3, S_PAUSE, 1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd4, 1'b0, 16'd3, S_PAUSE, 1'b0, 0));
        vecs.push_back(mk(OP_START, 16'd9, 1'b1, 16'd3, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b1, 16'd2, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b1, 16'd1, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd9, 1'b1, 16'd0, S_DONE,  1'b1, 1));
        vecs.push_back(mk(OP_ACK,   16'd9, 1'b1, 16'd0, S_DONE,  1'b0, 0));
        // zero load, full-scale load, stop beating start in RUN
        vecs.push_back(mk(OP_START, 16'd0, 1'b0, 16'd0, S_DONE,  1'b1, 1));
        vecs.push_back(mk(OP_ACK,   16'd0, 1'b0, 16'd0, S_DONE,  1'b0, 0));
        vecs.push_back(mk(OP_START, 16'hFFFF, 1'b0, 16'hFFFF, S_RUN, 1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd0, 1'b0, 16'hFFFE, S_RUN, 1'b0, 0));
        vecs.push_back(mk(OP_SS,    16'd7, 1'b0, 16'hFFFE, S_PAUSE, 1'b0, 0));
        vecs.push_back(mk(OP_STOP,  16'd7, 1'b0, 16'd0, S_IDLE,  1'b0, 0));
        // restart while running re-latches value and mode
        vecs.push_back(mk(OP_START, 16'd5, 1'b1, 16'd5, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_START, 16'd1, 1'b0, 16'd1, S_RUN,   1'b0, 0));
        vecs.push_back(mk(OP_TICK,  16'd1, 1'b0, 16'd0, S_DONE,  1'b1, 1));
        vecs.push_back(mk(OP_ACK,   16'd1, 1'b0, 16'd0, S_DONE,  1'b0, 0));
        vecs.push_back(mk(OP_STOP,  16'd1, 1'b0, 16'd0, S_IDLE,  1'b0, 0));

        for (int i = 0; i < vecs.size(); i++) run_op(i, vecs[i]);

        // Exact tick latency: sampled at E0, count changes at E2.
        @(negedge clk); start = 1'b1; load_val = 16'd3; mode = 1'b0;
        @(negedge clk); start = 1'b0; tick_in = 1'b1;
        @(posedge clk); #1; chk("lat.e0", 32'(count), 32'd3);
        @(negedge clk); tick_in = 1'b0;
        @(posedge clk); #1; chk("lat.e1", 32'(count), 32'd3);
        @(posedge clk); #1; chk("lat.e2", 32'(count), 32'd2);

        // tick_in held high for 10 cycles decrements once.
        @(negedge clk); tick_in = 1'b1;
        repeat (10) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold.count", 32'(count), 32'd1);
        chk("hold.state", 32'(state), 32'(S_RUN));
        stop = 1'b1; @(negedge clk); @(negedge clk); stop = 1'b0;
        @(negedge clk);
        chk("hold.idle", 32'(state), 32'(S_IDLE));

        // Expiry coincident with irq_ack: set wins.
        @(negedge clk); start = 1'b1; load_val = 16'd1; mode = 1'b1;
        @(negedge clk); start = 1'b0; tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("coin.irq_before", 32'(irq), 32'd1);
        tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk); irq_ack = 1'b1;
        @(posedge clk); #1;
        chk("coin.expired", 32'(expired), 32'd1);
        chk("coin.irq", 32'(irq), 32'd1);
        chk("coin.count", 32'(count), 32'd1);
        @(negedge clk); irq_ack = 1'b0;
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        chk("coin.ack_clears", 32'(irq), 32'd0);
        stop = 1'b1; @(negedge clk); @(negedge clk); stop = 1'b0;

        // Asynchronous reset mid-run with irq pending.
        @(negedge clk); start = 1'b1; load_val = 16'd0;
        @(negedge clk); load_val = 16'd5;
        @(negedge clk); start = 1'b0;
        chk("arst.pre_count", 32'(count), 32'd5);
        chk("arst.pre_irq", 32'(irq), 32'd1);
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.expired", 32'(expired), 32'd0);
        chk("arst.irq", 32'(irq), 32'd0);
        chk("arst.state", 32'(state), 32'(S_IDLE));
        @(negedge clk); clr = 1'b1;
        p0 = pulse_cnt;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst.post_state", 32'(state), 32'(S_IDLE));
        chk("arst.post_count", 32'(count), 32'd0);
        chk("arst.post_pulses", 32'(pulse_cnt - p0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
